// File: rtl/lsu_rmw.sv
// Load/store unit driving a single-port word RAM (1-cycle read latency); sub-word stores use read-modify-write.
// Optional: define LSU_BOUNDS_CHECK_EN to flag addresses beyond the RAM as errors instead of wrapping.
module lsu_rmw #(
    parameter int WORD_ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [WORD_ADDR_W-1:0] mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata
);

    typedef enum logic [2:0] {IDLE, ERR, RD, RD_WAIT, WR} state_t;

    state_t                 state_q;
    logic                   we_q;
    logic [2:0]             f3_q;
    logic [1:0]             lane_q;
    logic [15:0]            wdata_q;
    logic                   ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic                   mem_re_q;
    logic                   mem_we_q;
    logic [WORD_ADDR_W-1:0] mem_addr_q;
    logic [31:0]            mem_wdata_q;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        oob;
    logic        req_err;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_d;
    logic [31:0] merged_d;

    assign accept = req_valid & ready_q;

    assign illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111) || (req_funct3[2] && req_we);
    assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob = |req_addr[31:WORD_ADDR_W+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:WORD_ADDR_W+2];
    assign oob = 1'b0;
`endif

    assign req_err = illegal | misaligned | oob;

    always_comb begin
        byte_sel = 8'h00;
        unique case (lane_q)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_d = mem_rdata;
        case (f3_q)
            3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_d = {24'h0, byte_sel};
            3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_d = {16'h0, half_sel};
            default: load_d = mem_rdata;
        endcase

        merged_d = mem_rdata;
        if (f3_q[0]) begin
            if (lane_q[1]) merged_d[31:16] = wdata_q;
            else           merged_d[15:0]  = wdata_q;
        end else begin
            unique case (lane_q)
                2'd0: merged_d[7:0]   = wdata_q[7:0];
                2'd1: merged_d[15:8]  = wdata_q[7:0];
                2'd2: merged_d[23:16] = wdata_q[7:0];
                2'd3: merged_d[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_err) begin
                            state_q     <= ERR;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we && req_funct3[1:0] == 2'b10) begin
                            state_q     <= WR;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= req_addr[WORD_ADDR_W+1:2];
                            mem_wdata_q <= req_wdata;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q    <= RD;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= req_addr[WORD_ADDR_W+1:2];
                        end
                    end
                end
                RD: begin
                    // Load response is registered here so it lines up with mem_rdata in RD_WAIT.
                    state_q     <= RD_WAIT;
                    rsp_valid_q <= ~we_q;
                end
                RD_WAIT: begin
                    if (we_q) begin
                        state_q     <= WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged_d;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (state_q == RD_WAIT && !we_q) ? load_d : '0;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed table-driven bench for lsu_rmw with a behavioural 1-cycle-latency word RAM.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [14:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    lsu_rmw #(.WORD_ADDR_W(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram [0:(1<<15)-1];

    always @(posedge clk) begin
        if (rst) begin
            ram[0] <= 32'h0BADF00D;
            ram[4] <= 32'h8899AABB;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          re_n;
        int          we_n;
        logic [31:0] mwdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic [31:0] rdata, logic err, int lat, int re_n, int we_n,
                                logic [31:0] mwdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.lat = lat; v.re_n = re_n; v.we_n = we_n; v.mwdata = mwdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk({nm, ".ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string       nm;
        int          rsp_n, lat_a, re_n, we_n, re_cyc, we_cyc, glitch;
        logic [31:0] rd, wd;
        logic [14:0] ra, wa;
        logic        er, rdy_after;
        logic [14:0] exp_ma;
        nm = $sformatf("v%0d", idx);
        exp_ma = v.addr[16:2];
        rsp_n = 0; lat_a = -1; re_n = 0; we_n = 0; re_cyc = -1; we_cyc = -1; glitch = 0;
        rd = '0; wd = '0; ra = '0; wa = '0; er = 1'b0; rdy_after = 1'b0;
        @(negedge clk);
        wait_ready(nm);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (mem_re) begin re_n++; re_cyc = cyc; ra = mem_addr; end
            if (mem_we) begin we_n++; we_cyc = cyc; wa = mem_addr; wd = mem_wdata; end
            if (mem_re && mem_we) glitch++;
            if (rsp_valid) begin
                rsp_n++; lat_a = cyc; rd = rsp_rdata; er = rsp_err;
            end else if (rsp_rdata != 32'h0 || rsp_err) begin
                glitch++;
            end
            if (cyc == v.lat + 1) rdy_after = req_ready;
        end
        chk({nm, ".rsp_count"}, rsp_n, 1);
        chk({nm, ".latency"}, lat_a, v.lat);
        chk({nm, ".rdata"}, rd, v.rdata);
        chk({nm, ".err"}, {31'h0, er}, {31'h0, v.err});
        chk({nm, ".re_count"}, re_n, v.re_n);
        chk({nm, ".we_count"}, we_n, v.we_n);
        chk({nm, ".glitch"}, glitch, 0);
        chk({nm, ".ready_after"}, {31'h0, rdy_after}, 32'h1);
        if (v.re_n > 0) begin
            chk({nm, ".re_cycle"}, re_cyc, 1);
            chk({nm, ".re_addr"}, {17'h0, ra}, {17'h0, exp_ma});
        end
        if (v.we_n > 0) begin
            chk({nm, ".we_cycle"}, we_cyc, v.lat);
            chk({nm, ".we_addr"}, {17'h0, wa}, {17'h0, exp_ma});
            chk({nm, ".wdata"}, wd, v.mwdata);
        end
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({nm, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({nm, ".rsp_err"}, {31'h0, rsp_err}, 32'h0);
        chk({nm, ".rsp_rdata"}, rsp_rdata, 32'h0);
        chk({nm, ".mem_re"}, {31'h0, mem_re}, 32'h0);
        chk({nm, ".mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({nm, ".mem_addr"}, {17'h0, mem_addr}, 32'h0);
        chk({nm, ".mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        int stray;
        // load/store: we f3 addr wdata | rdata err lat re we mwdata
        vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0, 32'h00000088, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h12, 32'h0, 32'h00008899, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFBB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'h11, 32'h0, 32'h000000AA, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF99, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h11, 32'h1234565A, 32'h0, 0, 3, 1, 1, 32'h88995ABB));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'h88995ABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h12, 32'hCAFE1234, 32'h0, 0, 3, 1, 1, 32'h12345ABB));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'h12345ABB, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 0, 1, 0, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'h23, 32'h000000A5, 32'h0, 0, 3, 1, 1, 32'hA5ADBEEF));
        vecs.push_back(mk(1, 3'b001, 32'h20, 32'h00007777, 32'h0, 0, 3, 1, 1, 32'hA5AD7777));
        vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'hA5AD7777, 0, 2, 1, 0, 32'h0));
        // errors: misaligned and illegal size codes
        vecs.push_back(mk(0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'h13, 32'hFFFF, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'h11, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'h21, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
`ifdef LSU_BOUNDS_CHECK_EN
        vecs.push_back(mk(0, 3'b010, 32'h0002_0000, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0));
`else
        vecs.push_back(mk(0, 3'b010, 32'h0002_0000, 32'h0, 32'h0BADF00D, 0, 2, 1, 0, 32'h0));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Reset while a sub-word store sits in RD_WAIT: the write must never happen.
        @(negedge clk);
        wait_ready("rmid");
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h10; req_wdata = 32'h1111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_vals("rmid");
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_we || rsp_valid) stray++;
        end
        chk("rmid.stray_pulses", stray, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
